// File: rtl/alu_mem_pkg.sv
// Shared definitions for the ALU-with-memory engine.
//   op_t    : 4-bit command opcode (codes 9..15 are illegal)
//   state_t : control FSM states
//   FLAG_*  : bit positions inside the 4-bit {C, V, N, Z} flag vector
package alu_mem_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_WR  = 4'd1,
        OP_RD  = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    // Two-operand ops that read A and B and write back to D.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'd3) && (op <= 4'd8);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= 4'd8;
    endfunction

endpackage

// File: rtl/alu_mem_alu.sv
// Combinational ALU for the engine.
//   i_op     : opcode (only ADD..SHL produce a result; anything else gives 0)
//   i_a, i_b : operands
//   o_result : result modulo 2^WIDTH
//   o_flags  : {C, V, N, Z} at FLAG_* positions
module alu_mem_alu
    import alu_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    logic [WIDTH:0] w_ext;
    logic           w_c;
    logic           w_v;

    always_comb begin
        w_ext    = '0;
        o_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_ext    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_ext[WIDTH-1:0];
                w_c      = w_ext[WIDTH];
                // Overflow: both operands share a sign the result lacks.
                w_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extended difference goes negative exactly when A < B.
                w_ext    = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_ext[WIDTH-1:0];
                w_c      = w_ext[WIDTH];
                w_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                w_c      = i_a[WIDTH-1];
            end
            default: ;
        endcase
        o_flags         = '0;
        o_flags[FLAG_Z] = (o_result == '0);
        o_flags[FLAG_N] = o_result[WIDTH-1];
        o_flags[FLAG_V] = w_v;
        o_flags[FLAG_C] = w_c;
    end

endmodule

// File: rtl/alu_mem_unit.sv
// ALU-with-memory engine: DEPTH x WIDTH operand store, one command at a time.
//   clk, rst                    : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         : command channel; fields latched on accept
//   cmd_op, cmd_addr_a/b/d      : opcode and source A / source B / destination
//   cmd_wdata                   : write data for WR
//   rsp_valid/rsp_ready         : response channel, one response per command
//   rsp_data, rsp_flags, rsp_err: result word, {C,V,N,Z}, illegal-opcode flag
//   dbg_state                   : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The response holds its payload stable until it transfers, and no output
// depends combinationally on rsp_ready.
module alu_mem_unit
    import alu_mem_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_addr_a,
    input  logic [AW-1:0]    cmd_addr_b,
    input  logic [AW-1:0]    cmd_addr_d,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output state_t           dbg_state
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_mem_unit: DEPTH must be a power of two and at least 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("alu_mem_unit: WIDTH must be at least 2");
    end

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic [AW-1:0]    r_addr_a;
    logic [AW-1:0]    r_addr_b;
    logic [AW-1:0]    r_addr_d;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rsp_data;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_res;
    logic [3:0]       w_alu_flags;

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

    alu_mem_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (cmd_op == OP_RD || is_alu_op(cmd_op)) w_next = RD_A;
                else                                       w_next = RESP;
            end
            RD_A:    w_next = (r_op == OP_RD) ? RESP : RD_B;
            RD_B:    w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: storage, latched command fields, operands and response payload.
    // Reset clears the whole store, so an aborted command never writes back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem       <= '{default: '0};
            r_op        <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_d    <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op        <= cmd_op;
                    r_addr_a    <= cmd_addr_a;
                    r_addr_b    <= cmd_addr_b;
                    r_addr_d    <= cmd_addr_d;
                    // WR, NOP and illegal codes respond straight away.
                    r_rsp_data  <= (cmd_op == OP_WR) ? cmd_wdata : '0;
                    r_rsp_flags <= '0;
                    r_rsp_err   <= !is_legal_op(cmd_op);
                    if (cmd_op == OP_WR) r_mem[cmd_addr_d] <= cmd_wdata;
                end
                RD_A: begin
                    r_opa <= r_mem[r_addr_a];
                    if (r_op == OP_RD) r_rsp_data <= r_mem[r_addr_a];
                end
                RD_B: r_opb <= r_mem[r_addr_b];
                EXEC: begin
                    r_mem[r_addr_d] <= w_alu_res;
                    r_rsp_data      <= w_alu_res;
                    r_rsp_flags     <= w_alu_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mem_unit.sv
// Bench for alu_mem_unit: a word-level model of the engine checked every cycle
// against the 8-bit instance, directed vectors with hand-computed results, and
// a short 16-bit / 64-word scenario on a second instance.
module tb_alu_mem_unit;
    import alu_mem_pkg::*;

    localparam int BUDGET = 30;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [3:0] cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_d = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       rsp_err;
    state_t     dbg8;

    alu_mem_unit #(.WIDTH(8), .DEPTH(16)) dut8 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_d(cmd_addr_d),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .dbg_state(dbg8)
    );

    // ---------------- 16-bit / 64-word instance ----------------
    logic        c16_valid = 1'b0;
    logic        c16_ready;
    logic [3:0]  c16_op = '0;
    logic [5:0]  c16_a = '0, c16_b = '0, c16_d = '0;
    logic [15:0] c16_wdata = '0;
    logic        r16_valid;
    logic [15:0] r16_data;
    logic [3:0]  r16_flags;
    logic        r16_err;
    state_t      dbg16;

    alu_mem_unit #(.WIDTH(16), .DEPTH(64)) dut16 (
        .clk(clk), .rst(rst),
        .cmd_valid(c16_valid), .cmd_ready(c16_ready), .cmd_op(c16_op),
        .cmd_addr_a(c16_a), .cmd_addr_b(c16_b), .cmd_addr_d(c16_d),
        .cmd_wdata(c16_wdata),
        .rsp_valid(r16_valid), .rsp_ready(1'b1), .rsp_data(r16_data),
        .rsp_flags(r16_flags), .rsp_err(r16_err), .dbg_state(dbg16)
    );

    // ---------------- counters / check helper ----------------
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model + scoreboard (8-bit instance) ----------------
    int         m_mem [16];
    logic [7:0] exp_q  [$];   // expected rsp_data, one per outstanding command
    logic [4:0] expf_q [$];   // expected {err, C, V, N, Z}
    int         m_cnt = 0;    // cycles before rsp_valid may rise
    bit         m_idle;

    function automatic int sgn8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic void model_accept(input int op, input int a, input int b, input int d, input int wd);
        int x, y, r, s, lat;
        bit c, v, err, alu;
        x = m_mem[a]; y = m_mem[b];
        r = 0; c = 0; v = 0; err = 0; alu = 1; lat = 4;
        case (op)
            0: begin alu = 0; lat = 1; end
            1: begin alu = 0; lat = 1; r = wd; m_mem[d] = wd; end
            2: begin alu = 0; lat = 2; r = x; end
            3: begin
                r = (x + y) % 256; c = (x + y) >= 256;
                s = sgn8(x) + sgn8(y); v = (s > 127) || (s < -128);
            end
            4: begin
                r = (x - y + 256) % 256; c = x < y;
                s = sgn8(x) - sgn8(y); v = (s > 127) || (s < -128);
            end
            5: r = x & y;
            6: r = x | y;
            7: r = x ^ y;
            8: begin r = (x * 2) % 256; c = x >= 128; end
            default: begin alu = 0; lat = 1; err = 1; end
        endcase
        if (alu) m_mem[d] = r;
        exp_q.push_back(r[7:0]);
        if (alu) expf_q.push_back({err, c, v, r >= 128, r == 0});
        else     expf_q.push_back({err, 4'b0000});
        m_cnt = lat - 1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_cmd_ready", 32'(cmd_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_data",  32'(rsp_data), 0);
            chk("rst_rsp_flags", 32'(rsp_flags), 0);
            chk("rst_rsp_err",   32'(rsp_err), 0);
            exp_q.delete();
            expf_q.delete();
            m_cnt = 0;
            foreach (m_mem[i]) m_mem[i] = 0;
        end else begin
            m_idle = (exp_q.size() == 0);
            chk("cmd_ready", 32'(cmd_ready), 32'(m_idle));
            if (m_idle) begin
                chk("rsp_valid_idle", 32'(rsp_valid), 0);
            end else if (m_cnt > 0) begin
                chk("rsp_valid_early", 32'(rsp_valid), 0);
                m_cnt--;
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 1);
                chk("rsp_data",  32'(rsp_data), 32'(exp_q[0]));
                chk("rsp_flags", 32'(rsp_flags), 32'(expf_q[0][3:0]));
                chk("rsp_err",   32'(rsp_err), 32'(expf_q[0][4]));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    void'(expf_q.pop_front());
                end
            end
            if (cmd_valid && m_idle)
                model_accept(int'(cmd_op), int'(cmd_addr_a), int'(cmd_addr_b),
                             int'(cmd_addr_d), int'(cmd_wdata));
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one command, returns the response and the cycle latency from accept.
    // hold > 0 keeps rsp_ready low for that many cycles after rsp_valid rises.
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic [7:0] wd, input int hold,
                        output logic [7:0] data, output logic [3:0] fl, output logic er,
                        output int lat);
        int n;
        bit acc;
        data = '0; fl = '0; er = 1'b0; lat = 0;
        rsp_ready  = (hold == 0);
        cmd_valid  = 1'b1; cmd_op = op;
        cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d; cmd_wdata = wd;
        n = 0; acc = 0;
        while (!acc && n < BUDGET) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        do begin
            @(negedge clk); lat++;
        end while (!rsp_valid && lat < BUDGET);
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        data = rsp_data; fl = rsp_flags; er = rsp_err;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("bp_rsp_valid", 32'(rsp_valid), 1);
                chk("bp_cmd_ready", 32'(cmd_ready), 0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic send16(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] d, input logic [15:0] wd,
                          output logic [15:0] data, output logic [3:0] fl, output int lat);
        int n;
        bit acc;
        data = '0; fl = '0; lat = 0;
        c16_valid = 1'b1; c16_op = op; c16_a = a; c16_b = b; c16_d = d; c16_wdata = wd;
        n = 0; acc = 0;
        while (!acc && n < BUDGET) begin
            @(negedge clk); acc = c16_ready;
            @(posedge clk); #1; n++;
        end
        c16_valid = 1'b0;
        if (!acc) begin
            chk("w16_accept_timeout", 0, 1);
            return;
        end
        do begin
            @(negedge clk); lat++;
        end while (!r16_valid && lat < BUDGET);
        if (!r16_valid) begin
            chk("w16_rsp_timeout", 0, 1);
            return;
        end
        data = r16_data; fl = r16_flags;
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0]  d8;
        logic [15:0] d16;
        logic [3:0]  fl;
        logic        er;
        int          lat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Fresh store reads zero, response two cycles after accept.
        send(OP_RD, 4'd5, 4'd0, 4'd0, 8'h00, 0, d8, fl, er, lat);
        chk("rd0_data", 32'(d8), 32'h00);
        chk("rd0_flags", 32'(fl), 0);
        chk("rd0_lat", 32'(lat), 2);

        send(OP_WR, 4'd0, 4'd0, 4'd3, 8'h7F, 0, d8, fl, er, lat);
        chk("wr3_data", 32'(d8), 32'h7F);
        chk("wr3_lat", 32'(lat), 1);
        send(OP_WR, 4'd0, 4'd0, 4'd4, 8'h01, 0, d8, fl, er, lat);

        // 0x7F + 0x01 = 0x80: signed overflow, negative, no carry.
        send(OP_ADD, 4'd3, 4'd4, 4'd5, 8'h00, 0, d8, fl, er, lat);
        chk("add_data", 32'(d8), 32'h80);
        chk("add_flags", 32'(fl), 32'b0110);
        chk("add_lat", 32'(lat), 4);
        send(OP_RD, 4'd5, 4'd0, 4'd0, 8'h00, 0, d8, fl, er, lat);
        chk("rd5_data", 32'(d8), 32'h80);

        // 0x01 - 0x7F = 0x82 with borrow.
        send(OP_SUB, 4'd4, 4'd3, 4'd6, 8'h00, 0, d8, fl, er, lat);
        chk("sub_data", 32'(d8), 32'h82);
        chk("sub_flags", 32'(fl), 32'b1010);

        // Fully overlapping addresses: operand read before writeback.
        send(OP_XOR, 4'd3, 4'd3, 4'd3, 8'h00, 0, d8, fl, er, lat);
        chk("xor_data", 32'(d8), 32'h00);
        chk("xor_flags", 32'(fl), 32'b0001);
        send(OP_RD, 4'd3, 4'd0, 4'd0, 8'h00, 0, d8, fl, er, lat);
        chk("rd3_data", 32'(d8), 32'h00);

        send(OP_WR, 4'd0, 4'd0, 4'd7, 8'hC3, 0, d8, fl, er, lat);
        send(OP_WR, 4'd0, 4'd0, 4'd8, 8'h96, 0, d8, fl, er, lat);
        send(OP_AND, 4'd7, 4'd8, 4'd9, 8'h00, 0, d8, fl, er, lat);
        chk("and_data", 32'(d8), 32'h82);
        chk("and_flags", 32'(fl), 32'b0010);
        send(OP_OR, 4'd7, 4'd8, 4'd10, 8'h00, 0, d8, fl, er, lat);
        chk("or_data", 32'(d8), 32'hD7);
        send(OP_SHL, 4'd7, 4'd0, 4'd11, 8'h00, 0, d8, fl, er, lat);
        chk("shl_data", 32'(d8), 32'h86);
        chk("shl_flags", 32'(fl), 32'b1010);
        // 0xC3 + 0x96 = 0x159: carry and signed overflow, positive result.
        send(OP_ADD, 4'd7, 4'd8, 4'd12, 8'h00, 0, d8, fl, er, lat);
        chk("add2_data", 32'(d8), 32'h59);
        chk("add2_flags", 32'(fl), 32'b1100);
        send(OP_SUB, 4'd8, 4'd8, 4'd13, 8'h00, 0, d8, fl, er, lat);
        chk("sub0_flags", 32'(fl), 32'b0001);
        send(OP_NOP, 4'd0, 4'd0, 4'd0, 8'hAA, 0, d8, fl, er, lat);
        chk("nop_data", 32'(d8), 0);
        chk("nop_lat", 32'(lat), 1);

        // Backpressure on a pending RD.
        send(OP_RD, 4'd9, 4'd0, 4'd0, 8'h00, 3, d8, fl, er, lat);
        chk("bp_data", 32'(d8), 32'h82);
        @(negedge clk);
        chk("bp_ready_after", 32'(cmd_ready), 1);
        @(posedge clk); #1;

        // Illegal opcode must not disturb word 9.
        send(4'hF, 4'd0, 4'd0, 4'd9, 8'hAA, 0, d8, fl, er, lat);
        chk("ill_err", 32'(er), 1);
        chk("ill_data", 32'(d8), 0);
        chk("ill_lat", 32'(lat), 1);
        send(OP_RD, 4'd9, 4'd0, 4'd0, 8'h00, 0, d8, fl, er, lat);
        chk("ill_mem", 32'(d8), 32'h82);

        // Reset while an ADD is in EXEC: no response, store cleared.
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_addr_a = 4'd7; cmd_addr_b = 4'd8; cmd_addr_d = 4'd14;
        @(negedge clk);
        chk("rx_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rx_in_exec", 32'(dbg8), 32'(EXEC));
        rst = 1'b1;
        @(negedge clk);
        chk("rx_no_rsp", 32'(rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(OP_RD, 4'(i), 4'd0, 4'd0, 8'h00, 0, d8, fl, er, lat);
            chk("rx_cleared", 32'(d8), 0);
        end

        // Wider instance: 0x7FFF + 0x0001.
        send16(OP_WR, 6'd0, 6'd0, 6'd10, 16'h7FFF, d16, fl, lat);
        send16(OP_WR, 6'd0, 6'd0, 6'd20, 16'h0001, d16, fl, lat);
        send16(OP_ADD, 6'd10, 6'd20, 6'd40, 16'h0000, d16, fl, lat);
        chk("w16_add_data", 32'(d16), 32'h8000);
        chk("w16_add_flags", 32'(fl), 32'b0110);
        chk("w16_add_lat", 32'(lat), 4);
        send16(OP_RD, 6'd40, 6'd0, 6'd0, 16'h0000, d16, fl, lat);
        chk("w16_rd_data", 32'(d16), 32'h8000);
        send16(OP_SUB, 6'd20, 6'd10, 6'd41, 16'h0000, d16, fl, lat);
        chk("w16_sub_data", 32'(d16), 32'h8002);
        chk("w16_sub_flags", 32'(fl), 32'b1010);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        chk("watchdog", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mem_unit.md
# alu_mem_unit

Parametrised ALU-with-memory engine, the successor to the fixed-size memory DUT driven through `mem_if`. It holds a DEPTH x WIDTH operand store and executes one command at a time: write, read, or a two-operand ALU op that reads two words, computes, and writes back. Commands arrive on a valid/ready channel, and each command returns exactly one response on a valid/ready channel with result, flags and error. It sits behind the bench interface as the DUT of the next-generation testbench.

## Interface
- WIDTH, 8: data word width, at least 2.
- DEPTH, 16: number of words, a power of two and at least 2; localparam AW = $clog2(DEPTH).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit accepts a command.
- cmd_op  in  4  opcode (op_t).
- cmd_addr_a, cmd_addr_b, cmd_addr_d  in  AW each  source A, source B, destination.
- cmd_wdata  in  WIDTH  write data (WR only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  result word.
- rsp_flags  out  4  {C, V, N, Z}.
- rsp_err  out  1  illegal opcode.

## Operation
- Opcodes: 0 NOP, 1 WR, 2 RD, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 SHL (A<<1). Codes 9-15 are illegal.
- FSM states and transitions:
  - IDLE: on accept, WR/NOP/illegal go to RESP, RD goes to RD_A, ALU ops go to RD_A.
  - RD_A: RD goes to RESP, ALU ops go to RD_B.
  - RD_B goes to EXEC.
  - EXEC goes to RESP.
  - RESP: returns to IDLE on rsp_valid && rsp_ready.
- cmd_ready = (state == IDLE) && !rst. A handshake is cmd_valid && cmd_ready. Command fields are latched at accept.
- WR: mem[addr_d] <= wdata at the accept edge. The response carries rsp_data = wdata and flags 0.
- RD: rsp_data = mem[addr_a], flags 0.
- ALU ops: opA is latched in RD_A and opB in RD_B. In EXEC the unit computes the result, writes mem[addr_d], and loads the response registers.
- Flag rules:
  - Z: result == 0.
  - N: result[WIDTH-1].
  - C: carry out for ADD; borrow (A < B unsigned) for SUB; A[WIDTH-1] for SHL; 0 otherwise.
  - V: signed overflow for ADD/SUB; 0 otherwise.
- All arithmetic is modulo 2^WIDTH.
- NOP: rsp_data 0, flags 0, err 0. Illegal opcode: rsp_data 0, flags 0, err 1, memory untouched.
- Address overlaps (D==A, D==B, A==B) are legal. Operands are read before writeback, and later commands see the new value.

## Timing
- Accept edge at cycle T. rsp_valid first rises in the following cycle:
  - WR, NOP and illegal: T+1.
  - RD: T+2.
  - ALU ops: T+4.
- rsp_valid, rsp_data, rsp_flags and rsp_err stay stable until the handshake. There is no combinational path from rsp_ready to any output.
- The next command can be accepted in the cycle after the response handshake. There is no overlap of commands.
- Reset values: state IDLE, every memory word 0, rsp_valid 0, rsp_data 0, rsp_flags 0, rsp_err 0, cmd_ready 0 while rst is high and 1 after release.
- Reset mid-command aborts the command: no writeback, no response. The memory clears.

## Structure
- Package alu_mem_pkg holds:
  - op_t enum (4-bit);
  - state_t enum {IDLE, RD_A, RD_B, EXEC, RESP};
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_V=2, FLAG_C=3.
- Sub-module alu_mem_alu: combinational, parametrised by WIDTH. Inputs op, a, b; outputs result and flags[3:0].
- Top holds the FSM, the storage array, the operand registers and the response registers.
- Elaboration assertion: DEPTH is a power of two.

## Test plan
WIDTH=8, DEPTH=16 unless stated.
- Reset, then RD a=5 -> rsp_data 0x00, flags 0, rsp_valid 2 cycles after accept.
- WR d=3 0x7F; WR d=4 0x01; ADD a=3 b=4 d=5 -> 0x80, C=0 V=1 N=1 Z=0, valid 4 cycles after accept; then RD a=5 -> 0x80.
- SUB a=4 b=3 d=6 -> 0x82, C=1 V=0 N=1 Z=0. XOR a=3 b=3 d=3 -> 0x00, Z=1, and RD a=3 afterwards -> 0x00.
- Backpressure: hold rsp_ready=0 for 3 cycles on a pending RD -> rsp_valid and rsp_data stable, cmd_ready=0; release -> handshake, cmd_ready=1 the next cycle.
- Illegal op 0xF -> rsp_err=1, rsp_data 0, valid at T+1, memory unchanged.
- Assert rst during EXEC of an ADD -> no response, all words read back 0.
- Repeat the ADD scenario at WIDTH=16, DEPTH=64: 0x7FFF + 0x0001 -> 0x8000, V=1.
